// File: rtl/fpu_rt_wb_arb_if.sv
// Root-unit writeback arbiter bundle: per-unit results in, one
// writeback tag plus delayed data out.
interface fpu_rt_wb_arb_if #(
   parameter int DATA_W = 84,
   parameter int REG_W  = 9
);
   logic                  except;
   logic                  wb_free;
   logic [3:0]            rt_vld;
   logic [4*DATA_W-1:0]   rt_res;
   logic [4*REG_W-1:0]    rt_reg;
   logic [4*10-1:0]       rt_ii;
   logic [4*13-1:0]       rt_op;
   logic [4*11-1:0]       rt_exc;
   logic [10:0]           exc_mask;
   logic [3:0]            rt_ack;
   logic [3:0]            out_en;
   logic [9:0]            out_ii;
   logic [12:0]           out_op;
   logic [REG_W-1:0]      fu_reg;
   logic                  fu_wen;
   logic [DATA_W-1:0]     out_data;
   logic                  out_data_vld;
   logic [10:0]           exc_raise;
   logic [10:0]           exc_flags;

   modport master (
      output except, wb_free, rt_vld, rt_res, rt_reg,
      output rt_ii, rt_op, rt_exc, exc_mask,
      input  rt_ack, out_en, out_ii, out_op, fu_reg,
      input  fu_wen, out_data, out_data_vld,
      input  exc_raise, exc_flags
   );

   modport slave (
      input  except, wb_free, rt_vld, rt_res, rt_reg,
      input  rt_ii, rt_op, rt_exc, exc_mask,
      output rt_ack, out_en, out_ii, out_op, fu_reg,
      output fu_wen, out_data, out_data_vld,
      output exc_raise, exc_flags
   );
endinterface

// File: rtl/fpu_rt_wb_arb.sv
// Round-robin writeback arbiter for four FP root units; tags now,
// data DATA_DLY cycles later. FPU_RT_EXC_EN carries exception flags.
module fpu_rt_wb_arb #(
   parameter int DATA_W   = 84,
   parameter int REG_W    = 9,
   parameter int DATA_DLY = 5
) (
   input logic            clk,
   input logic            rst,
   fpu_rt_wb_arb_if.slave bus
);
   logic [1:0]        ptr;
   logic [1:0]        gnt_idx;
   logic [1:0]        idx;
   logic              gnt_vld;
   logic [DATA_DLY:0] pv;
   logic [DATA_W-1:0] pd [DATA_DLY+1];

   // search starts at ptr and wraps; first valid unit wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr;
      idx     = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!gnt_vld && bus.rt_vld[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
      if (!(bus.wb_free && !bus.except && rst))
         gnt_vld = 1'b0;
   end

   assign bus.rt_ack = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= '0;
         bus.out_en <= '0;
         bus.fu_wen <= 1'b0;
         bus.out_ii <= '0;
         bus.out_op <= '0;
         bus.fu_reg <= '0;
      end else begin
         if (gnt_vld)
            ptr <= gnt_idx + 2'd1;
         bus.out_en <= gnt_vld ? 4'b1001 : 4'b0000;
         bus.fu_wen <= gnt_vld;
         bus.out_ii <= gnt_vld ?
            bus.rt_ii[int'(gnt_idx)*10 +: 10] : '0;
         bus.out_op <= gnt_vld ?
            bus.rt_op[int'(gnt_idx)*13 +: 13] : '0;
         bus.fu_reg <= gnt_vld ?
            bus.rt_reg[int'(gnt_idx)*REG_W +: REG_W] : '0;
      end
   end

   // flush drops every in-flight beat together with the tags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv <= '0;
         for (int i = 0; i <= DATA_DLY; i++)
            pd[i] <= '0;
      end else begin
         pv <= bus.except ? '0 : {pv[DATA_DLY-1:0], gnt_vld};
         pd[0] <= gnt_vld ?
            bus.rt_res[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
         for (int i = 1; i <= DATA_DLY; i++)
            pd[i] <= pd[i-1];
      end
   end

   assign bus.out_data_vld = pv[DATA_DLY];
   assign bus.out_data     = pv[DATA_DLY] ? pd[DATA_DLY] : '0;

`ifdef FPU_RT_EXC_EN
   logic [10:0] pe [DATA_DLY+1];
   logic [10:0] flags;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= DATA_DLY; i++)
            pe[i] <= '0;
      end else begin
         pe[0] <= gnt_vld ?
            bus.rt_exc[int'(gnt_idx)*11 +: 11] : '0;
         for (int i = 1; i <= DATA_DLY; i++)
            pe[i] <= pe[i-1];
      end
   end

   assign flags         = pv[DATA_DLY] ? pe[DATA_DLY] : '0;
   assign bus.exc_flags = flags;
   assign bus.exc_raise = flags & bus.exc_mask;
`else
   assign bus.exc_flags = '0;
   assign bus.exc_raise = '0;
`endif

endmodule
